// File: rtl/scan_decoder_pkg.sv
// ---------------------------------------------------------------------------
// scan_pkg
// Shared types and helpers for the select/scan decoder family.
//   scan_mode_t  : auto scan vs. manual (direct decode) selection
//   onehot_msb() : MSB-first one-hot encoding, index k -> bit (width-1-k)
// ---------------------------------------------------------------------------
package scan_pkg;

    typedef enum logic {
        SCAN_AUTO   = 1'b0,
        SCAN_MANUAL = 1'b1
    } scan_mode_t;

    // Widest one-hot vector the helper can produce; callers size-cast down.
    localparam int unsigned ONEHOT_MAX_W = 256;

    // Returns a vector with bit (width-1-idx) set. An out-of-range index
    // yields all zeros so a caller never sees a stray bit.
    function automatic logic [ONEHOT_MAX_W-1:0] onehot_msb(
        input int unsigned idx,
        input int unsigned width
    );
        logic [ONEHOT_MAX_W-1:0] result;
        result = '0;
        if ((idx < width) && (width <= ONEHOT_MAX_W)) begin
            result = ONEHOT_MAX_W'(1) << (width - 1 - idx);
        end
        return result;
    endfunction

endpackage

// File: rtl/scan_decoder_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Free-running prescaler producing a registered one-cycle pulse every
// PRESCALE enabled clock cycles.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset (count and tick cleared)
//   en    : count enable; low holds the count and suppresses the tick
//   tick  : registered pulse, high for the cycle after the count wraps
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int PRESCALE = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             tick_q;
    logic             tick_d;

    // Next-state for the prescaler. With PRESCALE=1 the count sits at 0,
    // which always equals CNT_LAST, so every enabled cycle wraps.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (en) begin
            if (count_q == CNT_LAST) begin
                count_d = '0;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Prescaler state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/scan_decoder.sv
// ---------------------------------------------------------------------------
// scan_decoder
// One-hot select generator with a built-in scan engine. In auto mode the
// index steps to the next enabled mask position on every prescaler tick;
// in manual mode it acts as a registered plain decoder of man_idx.
//   clk     : system clock, rising edge
//   reset   : synchronous active-high reset
//   en      : global enable; low freezes the scan and blanks sel_o
//   mode    : 0 = auto scan, 1 = manual decode of man_idx
//   man_idx : index used in manual mode
//   mask    : bit k high enables position k
//   sel_o   : registered MSB-first one-hot select (inverted if ACTIVE_LOW)
//   idx_o   : registered current index (drives the digit data mux)
//   tick_o  : one-cycle pulse at each prescaler wrap
// ---------------------------------------------------------------------------
module scan_decoder
    import scan_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int PRESCALE   = 100000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      man_idx,
    input  logic [(2**SEL_W)-1:0] mask,
    output logic [(2**SEL_W)-1:0] sel_o,
    output logic [SEL_W-1:0]      idx_o,
    output logic                  tick_o
);

    localparam int N = 2**SEL_W;
    localparam logic [N-1:0] INACTIVE = ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};

    logic [SEL_W-1:0] idx_q;
    logic [SEL_W-1:0] idx_d;
    logic [N-1:0]     sel_q;
    logic [N-1:0]     sel_d;
    logic             tick;
    logic [SEL_W-1:0] nextEnabled;
    logic [SEL_W-1:0] cand;
    logic             found;
    logic [N-1:0]     oneHot;
    scan_mode_t       modeSel;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (tick)
    );

    assign modeSel = scan_mode_t'(mode);

    // Circular search for the first enabled position after idx_q. The
    // offset N truncates to 0 and revisits idx_q itself, so a lone enabled
    // current position keeps the index; an empty mask leaves it unchanged.
    always_comb begin
        nextEnabled = idx_q;
        found       = 1'b0;
        cand        = idx_q;
        for (int d = 1; d <= N; d++) begin
            cand = idx_q + SEL_W'(d);
            if (!found && mask[cand]) begin
                nextEnabled = cand;
                found       = 1'b1;
            end
        end
    end

    // Next index, priority en=0 > mode > tick. The select is decoded from
    // the next index so sel_o and idx_o move on the same edge, and it is
    // blanked whenever the target position is masked off or en is low.
    always_comb begin
        idx_d = idx_q;
        if (en) begin
            if (modeSel == SCAN_MANUAL) begin
                idx_d = man_idx;
            end else if (tick) begin
                idx_d = nextEnabled;
            end
        end
        oneHot = N'(onehot_msb(32'(idx_d), N));
        sel_d  = INACTIVE;
        if (en && mask[idx_d]) begin
            sel_d = ACTIVE_LOW ? ~oneHot : oneHot;
        end
    end

    // Index and select registers; reset restarts the scan from index 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
            sel_q <= INACTIVE;
        end else begin
            idx_q <= idx_d;
            sel_q <= sel_d;
        end
    end

    assign sel_o  = sel_q;
    assign idx_o  = idx_q;
    assign tick_o = tick;

endmodule

// File: tb/tb_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_scan_decoder
// Two instances: A (SEL_W=2, PRESCALE=4, active-high) driven by a directed
// sequence, B (SEL_W=3, PRESCALE=1, active-low) free-running with full mask.
// A cycle-level reference model tracks both and is compared every cycle;
// hand-computed checkpoints pin the model to known values.
// ---------------------------------------------------------------------------
module tb_scan_decoder;

    typedef struct {
        int         cnt;
        bit         tick;
        int         idx;
        logic [7:0] sel;
    } model_t;

    logic       clk;
    logic       reset;
    logic       enA;
    logic       modeA;
    logic [1:0] manA;
    logic [3:0] maskA;
    logic [3:0] selA;
    logic [1:0] idxA;
    logic       tickA;
    logic [7:0] selB;
    logic [2:0] idxB;
    logic       tickB;

    int     compared   = 0;
    int     mismatched = 0;
    int     cycle      = 0;
    bit     modelValid = 0;
    model_t mA;
    model_t mB;

    scan_decoder #(
        .SEL_W      (2),
        .PRESCALE   (4),
        .ACTIVE_LOW (1'b0)
    ) dutA (
        .clk     (clk),
        .reset   (reset),
        .en      (enA),
        .mode    (modeA),
        .man_idx (manA),
        .mask    (maskA),
        .sel_o   (selA),
        .idx_o   (idxA),
        .tick_o  (tickA)
    );

    scan_decoder #(
        .SEL_W      (3),
        .PRESCALE   (1),
        .ACTIVE_LOW (1'b1)
    ) dutB (
        .clk     (clk),
        .reset   (reset),
        .en      (1'b1),
        .mode    (1'b0),
        .man_idx (3'd0),
        .mask    (8'hFF),
        .sel_o   (selB),
        .idx_o   (idxB),
        .tick_o  (tickB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference behaviour for one clock edge, written from the scan rules:
    // prescaler wrap produces a tick seen one cycle later, an auto step looks
    // for the next enabled position circularly, outputs follow the new index.
    function automatic model_t modelStep(model_t m, bit rst, bit en, bit mode,
                                         int man, logic [7:0] mask, int n,
                                         int presc, bit al);
        model_t     r;
        logic [7:0] full;
        int         k;
        full = (n == 8) ? 8'hFF : 8'((1 << n) - 1);
        r = m;
        if (rst) begin
            r.cnt  = 0;
            r.tick = 0;
            r.idx  = 0;
            r.sel  = al ? full : 8'h00;
            return r;
        end
        r.tick = 0;
        if (en) begin
            if (m.cnt == presc - 1) begin
                r.cnt  = 0;
                r.tick = 1;
            end else begin
                r.cnt = m.cnt + 1;
            end
            if (mode) begin
                r.idx = man;
            end else if (m.tick) begin
                for (int d = 1; d <= n; d++) begin
                    k = (m.idx + d) % n;
                    if (mask[k]) begin
                        r.idx = k;
                        break;
                    end
                end
            end
        end
        r.sel = 8'h00;
        if (en && mask[r.idx]) r.sel = 8'(1 << (n - 1 - r.idx));
        if (al) r.sel = r.sel ^ full;
        return r;
    endfunction

    // Advance both models on every rising edge using the inputs that the
    // DUTs sample on that same edge.
    always @(posedge clk) begin
        mA = modelStep(mA, reset, enA, modeA, int'(manA), {4'b0, maskA}, 4, 4, 1'b0);
        mB = modelStep(mB, reset, 1'b1, 1'b0, 0, 8'hFF, 8, 1, 1'b1);
        if (reset) modelValid = 1;
        cycle++;
    end

    // Per-cycle comparison of every DUT output against the model, sampled
    // half a period away from the active edge.
    always @(negedge clk) begin
        if (modelValid) begin
            compared++;
            if (selA !== mA.sel[3:0] || int'(idxA) != mA.idx || tickA !== mA.tick) begin
                mismatched++;
                $display("[TB] FAIL modelA cycle=%0d got sel=%b idx=%0d tick=%b want sel=%b idx=%0d tick=%b",
                         cycle, selA, idxA, tickA, mA.sel[3:0], mA.idx, mA.tick);
            end
            compared++;
            if (selB !== mB.sel || int'(idxB) != mB.idx || tickB !== mB.tick) begin
                mismatched++;
                $display("[TB] FAIL modelB cycle=%0d got sel=%b idx=%0d tick=%b want sel=%b idx=%0d tick=%b",
                         cycle, selB, idxB, tickB, mB.sel, mB.idx, mB.tick);
            end
        end
    end

    // Drive instance A inputs; called just after a falling edge.
    task automatic applyStimulus(input bit rst, input bit en, input bit mode,
                                 input logic [1:0] man, input logic [3:0] mask);
        reset = rst;
        enA   = en;
        modeA = mode;
        manA  = man;
        maskA = mask;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hand-computed checkpoint against one instance (useB selects B).
    task automatic checkOutput(input string name, input bit useB,
                               input logic [7:0] expSel, input int expIdx,
                               input bit expTick);
        logic [7:0] gotSel;
        int         gotIdx;
        bit         gotTick;
        gotSel  = useB ? selB : {4'b0, selA};
        gotIdx  = useB ? int'(idxB) : int'(idxA);
        gotTick = useB ? tickB : tickA;
        compared++;
        if (gotSel !== expSel || gotIdx != expIdx || gotTick != expTick) begin
            mismatched++;
            $display("[TB] FAIL %s got sel=%b idx=%0d tick=%b want sel=%b idx=%0d tick=%b",
                     name, gotSel, gotIdx, gotTick, expSel, expIdx, expTick);
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 4'b1111);
        waitCycles(2);
        checkOutput("resetA", 0, 8'b0000, 0, 0);
        checkOutput("resetB", 1, 8'hFF, 0, 0);

        // Full-mask auto scan, steps every 4 cycles.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 4'b1111);
        waitCycles(1);
        checkOutput("scan0", 0, 8'b1000, 0, 0);
        checkOutput("B_first", 1, 8'h7F, 0, 1);
        waitCycles(3);
        checkOutput("tick1", 0, 8'b1000, 0, 1);
        checkOutput("B_idx3", 1, 8'hEF, 3, 1);
        waitCycles(1);
        checkOutput("scan1", 0, 8'b0100, 1, 0);
        waitCycles(4);
        checkOutput("scan2", 0, 8'b0010, 2, 0);
        checkOutput("B_wrap", 1, 8'h7F, 0, 1);
        waitCycles(4);
        checkOutput("scan3", 0, 8'b0001, 3, 0);
        waitCycles(4);
        checkOutput("scanWrap", 0, 8'b1000, 0, 0);

        // Sparse mask: only positions 1 and 3 enabled.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 4'b1010);
        waitCycles(1);
        checkOutput("maskBlank", 0, 8'b0000, 0, 0);
        waitCycles(3);
        checkOutput("skip1", 0, 8'b0100, 1, 0);
        waitCycles(4);
        checkOutput("skip3", 0, 8'b0001, 3, 0);
        waitCycles(4);
        checkOutput("skip1b", 0, 8'b0100, 1, 0);
        waitCycles(4);
        checkOutput("skip3b", 0, 8'b0001, 3, 0);

        // Empty mask: output blanks, index frozen across ticks.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 4'b0000);
        waitCycles(1);
        checkOutput("maskZero", 0, 8'b0000, 3, 0);
        waitCycles(8);
        checkOutput("maskZeroHold", 0, 8'b0000, 3, 0);

        // Enable dropped at count=2 for 10 cycles.
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'b1111);
        waitCycles(10);
        checkOutput("enOff", 0, 8'b0000, 3, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 4'b1111);
        waitCycles(1);
        checkOutput("enBack", 0, 8'b0001, 3, 0);
        waitCycles(1);
        checkOutput("enTick", 0, 8'b0001, 3, 1);
        waitCycles(1);
        checkOutput("enStep", 0, 8'b1000, 0, 0);

        // Manual mode decode, ticks ignored for idx.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 4'b1111);
        waitCycles(1);
        checkOutput("man2", 0, 8'b0010, 2, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 4'b1111);
        waitCycles(1);
        checkOutput("man0", 0, 8'b1000, 0, 0);
        waitCycles(2);
        checkOutput("manTickIgnored", 0, 8'b1000, 0, 0);

        // Back to auto: resumes from index 0 at the next tick.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 4'b1111);
        waitCycles(3);
        checkOutput("autoTick", 0, 8'b1000, 0, 1);
        waitCycles(1);
        checkOutput("autoResume", 0, 8'b0100, 1, 0);
        waitCycles(8);
        checkOutput("reachIdx3", 0, 8'b0001, 3, 0);
        waitCycles(1);

        // Reset mid-dwell at index 3.
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 4'b1111);
        waitCycles(1);
        checkOutput("midReset", 0, 8'b0000, 0, 0);
        checkOutput("midResetB", 1, 8'hFF, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 4'b1111);
        waitCycles(1);
        checkOutput("postReset", 0, 8'b1000, 0, 0);
        waitCycles(3);
        checkOutput("postResetTick", 0, 8'b1000, 0, 1);
        waitCycles(1);
        checkOutput("postResetStep", 0, 8'b0100, 1, 0);

        waitCycles(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
